// File: rtl/pulse_train_gen.sv
// Burst pulse generator: emits `count` one-cycle pulses separated by `gap` idle cycles,
// then a one-cycle done strobe. All outputs are driven straight from flops.
module pulse_train_gen #(
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned GAP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic [GAP_WIDTH-1:0] gap,
  input  logic                 abort,
  output logic                 busy,
  output logic                 pulse,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] sent
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPulse = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [GAP_WIDTH-1:0] gcnt_q, gcnt_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic [CNT_WIDTH-1:0] sent_inc;
  logic                 busy_q, busy_d;
  logic                 pulse_q, pulse_d;
  logic                 done_q, done_d;

  assign sent_inc = sent_q + CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    sent_d  = sent_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sent_d = '0;
          if (count != '0) begin
            cnt_d   = count;
            gap_d   = gap;
            state_d = StPulse;
          end else begin
            state_d = StDone;
          end
        end
      end

      StPulse: begin
        sent_d = sent_inc;
        // Abort beats the final-pulse condition: the pulse still counts, but no done.
        if (abort) begin
          state_d = StIdle;
        end else if (sent_inc == cnt_q) begin
          state_d = StDone;
        end else if (gap_q == '0) begin
          state_d = StPulse;
        end else begin
          gcnt_d  = gap_q;
          state_d = StGap;
        end
      end

      StGap: begin
        gcnt_d = gcnt_q - GAP_WIDTH'(1);
        if (abort) begin
          state_d = StIdle;
        end else if (gcnt_q == GAP_WIDTH'(1)) begin
          state_d = StPulse;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered copies of the next-state decode, so they align with state_q.
    busy_d  = (state_d != StIdle);
    pulse_d = (state_d == StPulse);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      sent_q  <= '0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign pulse = pulse_q;
  assign done  = done_q;
  assign sent  = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: expected per-cycle outputs come from the burst
// timing formula, are queued when a burst is launched and popped as cycles elapse.
module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] count;
  logic [15:0] gap;
  logic        abort;
  logic        busy;
  logic        pulse;
  logic        done;
  logic [63:0] sent;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        busy;
    logic        pulse;
    logic        done;
    logic [63:0] sent;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  pulse_train_gen #(
    .CNT_WIDTH(64),
    .GAP_WIDTH(16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .count(count),
    .gap  (gap),
    .abort(abort),
    .busy (busy),
    .pulse(pulse),
    .done (done),
    .sent (sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle N+%0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Pulses emitted in cycles 1..t of a burst with the given count and gap.
  function automatic int pulses_upto(input int t, input int cnt, input int gp);
    int k;
    if (t < 1) return 0;
    k = (t - 1) / (gp + 1) + 1;
    return (k > cnt) ? cnt : k;
  endfunction

  // Launch a burst at edge N and check cycles N+1..N+len.
  // abort_at / restart_at / rst_at: cycle index (0 = never) in which that input is high.
  task automatic run_burst(input int cnt, input int gp, input int abort_at, input int restart_at,
                           input int restart_cnt, input int rst_at, input int len);
    int   done_cyc;
    exp_t e;
    exp_t got;
    done_cyc = (cnt == 0) ? 1 : (cnt - 1) * (gp + 1) + 2;
    for (int j = 1; j <= len; j++) begin
      e.cyc = j;
      if (rst_at != 0 && j > rst_at) begin
        e.busy = 1'b0; e.pulse = 1'b0; e.done = 1'b0; e.sent = '0;
      end else if (abort_at != 0 && j > abort_at) begin
        e.busy = 1'b0; e.pulse = 1'b0; e.done = 1'b0;
        e.sent = 64'(pulses_upto(abort_at, cnt, gp));
      end else begin
        e.pulse = ((j - 1) % (gp + 1) == 0) && ((j - 1) / (gp + 1) < cnt);
        e.done  = (j == done_cyc);
        e.busy  = (j <= done_cyc);
        e.sent  = 64'(pulses_upto(j - 1, cnt, gp));
      end
      sb.push_back(e);
    end

    start = 1'b1;
    count = 64'(cnt);
    gap   = 16'(gp);
    @(posedge clk);
    #1;
    for (int j = 1; j <= len; j++) begin
      abort = (j == abort_at);
      rst   = (j == rst_at);
      if (j == restart_at) begin
        start = 1'b1;
        count = 64'(restart_cnt);
        gap   = 16'd0;
      end else begin
        start = 1'b0;
        count = '0;
        gap   = '0;
      end
      @(negedge clk);
      got = sb.pop_front();
      check("busy",  got.cyc, {63'd0, busy},  {63'd0, got.busy});
      check("pulse", got.cyc, {63'd0, pulse}, {63'd0, got.pulse});
      check("done",  got.cyc, {63'd0, done},  {63'd0, got.done});
      check("sent",  got.cyc, sent, got.sent);
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    rst   = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    count = '0;
    gap   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy",  0, {63'd0, busy},  64'd0);
    check("reset_pulse", 0, {63'd0, pulse}, 64'd0);
    check("reset_done",  0, {63'd0, done},  64'd0);
    check("reset_sent",  0, sent, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_burst(3, 0, 0, 0, 0, 0, 6);   // back-to-back pulses
    run_burst(2, 2, 0, 0, 0, 0, 6);   // gap of two idle cycles
    run_burst(0, 0, 0, 0, 0, 0, 3);   // zero count: straight to done
    run_burst(4, 1, 0, 2, 9, 0, 9);   // mid-burst start ignored
    run_burst(10, 0, 4, 0, 0, 0, 7);  // abort in PULSE
    run_burst(3, 2, 3, 0, 0, 0, 5);   // abort in GAP
    run_burst(3, 0, 3, 0, 0, 0, 5);   // abort coincides with final pulse
    run_burst(5, 3, 0, 0, 0, 6, 9);   // reset mid-burst
    run_burst(1, 0, 0, 0, 0, 0, 3);   // fresh start after reset
    run_burst(1, 0, 0, 2, 9, 0, 2);   // start during DONE ignored
    run_burst(2, 0, 0, 0, 0, 0, 4);   // start in first IDLE cycle accepted
    run_burst(3, 5, 0, 0, 0, 0, 16);  // wider gap

    // Abort while idle changes nothing.
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", 0, {63'd0, busy}, 64'd0);
    check("idle_abort_sent", 0, sent, 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
